// File: rtl/div_pkg.sv
// Shared constants for the sequential unsigned divider: state encoding,
// default operand width and the iteration-counter width helper.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,dividend} left, trial-subtract
// the divisor, and keep or restore the partial remainder.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] dvd_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] dvd_out,
  output logic             q_bit
);

  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff_lo;
  logic             carry_lo;
  logic             carry;

  always_comb begin
    sh = {rem_in, dvd_in[WIDTH-1]};
    {carry_lo, diff_lo} = {1'b0, sh[WIDTH-1:0]} + {1'b0, ~divisor} + {{WIDTH{1'b0}}, 1'b1};
    // Top adder bit adds sh[WIDTH] to the all-ones extension of ~divisor,
    // so its carry-out is sh[WIDTH] | carry_lo; carry=1 means sh >= divisor.
    carry   = sh[WIDTH] | carry_lo;
    q_bit   = carry;
    rem_out = carry ? diff_lo : sh[WIDTH-1:0];
    dvd_out = {dvd_in[WIDTH-2:0], carry};
  end

endmodule

// File: rtl/divu_seq.sv
// Sequential unsigned divider: one restoring step per clock, results held
// from one done pulse to the next.
//
// state   | meaning
// IDLE    | waiting for start; operands captured on accept
// RUN     | WIDTH restoring iterations, one per cycle
// DONE    | done pulse cycle; results already registered
module divu_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_dvd;
  logic             step_q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (prem_q),
    .dvd_in  (dvd_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .dvd_out (step_dvd),
    .q_bit   (step_q_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvd_d  = a;
          dvs_d  = b;
          prem_d = '0;
          cnt_d  = CW'(WIDTH);
          if (b == '0) begin
            state_d = ST_DONE;
            quo_d   = '1;
            rem_d   = a;
            dz_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        dvd_d  = step_dvd;
        prem_d = step_rem;
        cnt_d  = cnt_q - CW'(1);
        // Results land in the output registers on the edge that enters DONE.
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          quo_d   = step_dvd;
          rem_d   = step_rem;
          dz_d    = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign quo      = quo_q;
  assign rem      = rem_q;
  assign div_zero = dz_q;

  // The quotient bit is already folded into step_dvd; keep it visible on
  // the step boundary for debug without a second datapath.
  logic unused_q_bit;
  assign unused_q_bit = step_q_bit;

endmodule

// File: tb/tb_divu_seq.sv
// Directed and reference-model checks for divu_seq (WIDTH=32).
module tb_divu_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] quo, rem;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divu_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .quo      (quo),
    .rem      (rem),
    .div_zero (div_zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start a division once the divider is idle; return cycles to done
  // (cycle 1 is the first cycle after the accept edge), 0 on timeout.
  task automatic do_div(input logic [31:0] av, input logic [31:0] bv, output int lat);
    int w = 0;
    while (busy && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    start = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat == 0) chk("timeout_done", 64'd0, 64'd1);
  endtask

  initial begin
    int lat;
    int dones;
    logic [31:0] ra, rb;

    reset_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {busy, done, div_zero, quo, rem}, 67'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    // 100 / 7
    do_div(32'd100, 32'd7, lat);
    chk("d7_lat", lat, 33);
    chk("d7_quo", quo, 14);
    chk("d7_rem", rem, 2);
    chk("d7_dz", div_zero, 0);
    chk("d7_busy", busy, 1);
    @(posedge clk); #1;
    chk("d7_pulse", done, 0);
    chk("d7_idle", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("d7_hold", {quo, rem}, {32'd14, 32'd2});

    // divide by zero
    do_div(32'h12345678, 32'd0, lat);
    chk("dz_lat", lat, 1);
    chk("dz_quo", quo, 32'hFFFF_FFFF);
    chk("dz_rem", rem, 32'h1234_5678);
    chk("dz_flag", div_zero, 1);

    // back-to-back, second start in the cycle after done
    do_div(32'hFFFF_FFFF, 32'd1, lat);
    chk("bb1_lat", lat, 33);
    chk("bb1_quo", quo, 32'hFFFF_FFFF);
    chk("bb1_rem", rem, 0);
    chk("bb1_dz", div_zero, 0);
    do_div(32'd5, 32'd9, lat);
    chk("bb2_lat", lat, 33);
    chk("bb2_quo", quo, 0);
    chk("bb2_rem", rem, 5);

    // start while busy is ignored
    @(posedge clk); #1;
    start = 1'b1; a = 32'd50; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 10) begin start = 1'b1; a = 32'd9; b = 32'd3; end
      if (n == 11) start = 1'b0;
      if (done) begin
        dones++;
        if (lat == 0) begin
          lat = n;
          chk("ign_quo", quo, 10);
          chk("ign_rem", rem, 0);
        end
      end
      @(posedge clk); #1;
    end
    chk("ign_lat", lat, 33);
    chk("ign_ndone", dones, 1);

    // reset mid-division after a result is held
    do_div(32'd100, 32'd7, lat);
    @(posedge clk); #1;
    start = 1'b1; a = 32'd77; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("rmid_busy", busy, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("rmid_outs", {busy, done, div_zero, quo, rem}, 67'd0);
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      if (n == 2) reset_n = 1'b1;
      if (done) dones++;
      @(posedge clk); #1;
    end
    chk("rmid_nodone", dones, 0);
    do_div(32'd1000, 32'd10, lat);
    chk("rpost_lat", lat, 33);
    chk("rpost_res", {quo, rem}, {32'd100, 32'd0});

    // random pairs against the language's own unsigned divide
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 0) rb = 32'd1;
      if (i % 7 == 0) ra = ra >> 20;
      do_div(ra, rb, lat);
      chk("rnd_lat", lat, 33);
      chk("rnd_quo", quo, ra / rb);
      chk("rnd_rem", rem, ra % rb);
      chk("rnd_dz", div_zero, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
